bcd_to_binary: RTL

Sequential BCD-to-binary converter for the EVM datapath. It is the inverse of the tally display path: it takes a DIGITS-wide packed BCD value and returns its binary equivalent. Typical sources are keypad-entered candidate IDs and preset vote counts. Conversion uses reverse double-dabble (shift right, then subtract 3 from each nibble ≥ 8), one bit per clock, behind a start/busy/done handshake.

---
 rtl/evm_pkg.sv | 22 ++
 rtl/bcd_nibble_adjust.sv | 12 +
 rtl/bcd_to_binary.sv | 129 ++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared EVM datapath types and defaults.
// Used by the BCD-to-binary converter and its nibble adjuster.
package evm_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_BIN_W  = 14;

    typedef logic [3:0] bcd_digit_t;

    // Largest decimal value representable with the given digit count.
    function automatic longint unsigned max_decimal(input int digits);
        longint unsigned r;
        r = 0;
        for (int i = 0; i < digits; i++) begin
            r = r * 10 + 9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble digit correction.
// Subtracts 3 from a BCD nibble once it reaches 8 after a right shift.
module bcd_nibble_adjust
    import evm_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    assign d_o = d_i[3] ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter, one bit per clock.
// Define BCD_TO_BINARY_RANGE_CHECK_EN to flag digits above 9 via err.
module bcd_to_binary
    import evm_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    if ((BIN_W < 63) && ((64'd1 << BIN_W) <= max_decimal(DIGITS))) begin : g_width_chk
        $error("BIN_W too narrow for DIGITS");
    end

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORK_W-1:0]  work_q;
    logic               busy_q;
    logic               done_q;
    logic [BIN_W-1:0]   bin_out_q;

    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   bcd_adj;
    logic [WORK_W-1:0]  work_d;
    logic               last;

    assign shifted = work_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .d_i (shifted[BIN_W + 4*g +: 4]),
            .d_o (bcd_adj[4*g +: 4])
        );
    end

    assign work_d = {bcd_adj, shifted[BIN_W-1:0]};
    assign last   = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
    logic bcd_bad;
    logic bad_q;
    logic err_q;

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
                        bad_q   <= bcd_bad;
`endif
                    end
                end
                RUN: begin
`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
                    // Invalid input finishes on the first RUN edge.
                    if (bad_q) begin
                        bin_out_q <= '0;
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        bad_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
`else
                    begin
`endif
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last) begin
                            bin_out_q <= work_d[BIN_W-1:0];
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
                            err_q     <= 1'b0;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;

endmodule
